i2s_audio_tx: RTL and testbench

- Serialises the stereo 16-bit signed samples produced by the audio mixer into a standard I2S stream for the external DAC.
- Generates BCLK and LRCK from the system clock.
- Accepts sample pairs through a valid/ready handshake into a one-entry holding buffer.
- Streams each pair out MSB-first, one frame of 32 BCLK periods per stereo sample.

---
 rtl/i2s_audio_tx.sv | 94 +++++++++
 tb/tb_i2s_audio_tx.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/i2s_audio_tx.sv
// I2S transmitter: one-entry sample buffer, BCLK/LRCK generation and MSB-first
// serialisation of stereo WIDTH-bit samples, 2*WIDTH BCLK periods per frame.
module i2s_audio_tx #(
  parameter int CLK_DIV = 4,
  parameter int WIDTH   = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_l,
  input  logic [WIDTH-1:0] in_r,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             i2s_bclk,
  output logic             i2s_lrck,
  output logic             i2s_sdata,
  output logic             underrun
);

  localparam int FRAME = 2 * WIDTH;
  localparam int CW    = $clog2(FRAME);
  localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME - 1);
  localparam logic [CW-1:0] WS_FIRST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] WS_LAST  = CW'(FRAME - 2);

  logic [DW-1:0]    div_q, div_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] buf_l_q, buf_r_q;
  logic [WIDTH-1:0] shadow_l_q, shadow_r_q;
  logic [FRAME-1:0] frame_word;
  logic             div_wrap, fall, frame_start, load, accept;
  logic             sdata_d, lrck_d;

  // NOTE: every signal driven here is assigned on every pass, so no latches are inferred.
  always_comb begin
    div_wrap    = (div_q == DIV_LAST);
    div_d       = div_wrap ? '0 : div_q + 1'b1;
    fall        = div_wrap && i2s_bclk;
    frame_start = fall && (bit_cnt_q == CNT_LAST);
    // A frame start only consumes a pair that was already buffered before this clk.
    load        = frame_start && !in_ready;
    accept      = in_valid && in_ready;
    bit_cnt_d   = frame_start ? '0 : bit_cnt_q + 1'b1;
    frame_word  = load ? {buf_l_q, buf_r_q} : {shadow_l_q, shadow_r_q};
    sdata_d     = frame_word[CNT_LAST - bit_cnt_d];
    lrck_d      = (bit_cnt_d >= WS_FIRST) && (bit_cnt_d <= WS_LAST);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q      <= '0;
      bit_cnt_q  <= CNT_LAST;
      i2s_bclk   <= 1'b0;
      i2s_lrck   <= 1'b0;
      i2s_sdata  <= 1'b0;
      underrun   <= 1'b0;
      in_ready   <= 1'b1;
      shadow_l_q <= '0;
      shadow_r_q <= '0;
    end else begin
      div_q    <= div_d;
      underrun <= frame_start && in_ready;
      if (div_wrap) begin
        i2s_bclk <= !i2s_bclk;
      end
      if (fall) begin
        bit_cnt_q <= bit_cnt_d;
        i2s_sdata <= sdata_d;
        i2s_lrck  <= lrck_d;
      end
      if (load) begin
        shadow_l_q <= buf_l_q;
        shadow_r_q <= buf_r_q;
      end
      if (accept) begin
        in_ready <= 1'b0;
      end else if (load) begin
        in_ready <= 1'b1;
      end
    end
  end

  // NOTE: the buffer payload has no reset; it is only read while in_ready marks it full.
  always_ff @(posedge clk) begin
    if (accept) begin
      buf_l_q <= in_l;
      buf_r_q <= in_r;
    end
  end

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Bench for i2s_audio_tx: two lanes (CLK_DIV=2 and CLK_DIV=1), each with a frame-level
// reference model feeding a scoreboard and an I2S receiver-style monitor that checks it.
module tb_i2s_audio_tx;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] l;
    logic [W-1:0] r;
    bit           und;
  } frame_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit done[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int CD = (g == 0) ? 2 : 1;
    localparam int F  = 64 * CD;  // clk cycles per frame

    logic         rst_n    = 1'b0;
    logic [W-1:0] in_l     = '0;
    logic [W-1:0] in_r     = '0;
    logic         in_valid = 1'b0;
    logic         in_ready, bclk, lrck, sdata, und;

    i2s_audio_tx #(.CLK_DIV(CD), .WIDTH(W)) dut (
      .clk      (clk),
      .reset_n  (rst_n),
      .in_l     (in_l),
      .in_r     (in_r),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .i2s_bclk (bclk),
      .i2s_lrck (lrck),
      .i2s_sdata(sdata),
      .underrun (und)
    );

    // Reference model: cycle count since reset release, one-entry buffer, current pair.
    int           cyc    = 0;
    bit           m_full = 1'b0;
    bit           m_acc;
    frame_t       m_buf;
    logic [W-1:0] sh_l   = '0;
    logic [W-1:0] sh_r   = '0;
    frame_t       exp_q[$];

    initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        cyc    = 0;
        m_full = 1'b0;
        sh_l   = '0;
        sh_r   = '0;
        exp_q.delete();
      end else begin
        m_acc = in_valid && !m_full;
        cyc++;
        // BCLK falls every 2*CD clks; every 32nd fall, starting with the first, opens a frame.
        if ((cyc % (2 * CD) == 0) && ((cyc / (2 * CD)) % 32 == 1)) begin
          if (m_full) begin
            sh_l   = m_buf.l;
            sh_r   = m_buf.r;
            m_full = 1'b0;
            exp_q.push_back('{sh_l, sh_r, 1'b0});
          end else begin
            exp_q.push_back('{sh_l, sh_r, 1'b1});
          end
        end
        if (m_acc) begin
          m_buf  = '{in_l, in_r, 1'b0};
          m_full = 1'b1;
        end
      end
    end

    // Monitor: decodes the stream like a DAC, sampling on BCLK rising edges.
    int           slot;
    int           ucnt;
    bit           prev_bclk;
    logic [2*W-1:0] word;
    frame_t       ef;

    initial forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        slot      = -1;
        ucnt      = 0;
        prev_bclk = 1'b0;
        check($sformatf("lane%0d reset outputs", g), {in_ready, bclk, lrck, sdata, und}, 5'b10000);
      end else begin
        check($sformatf("lane%0d in_ready", g), in_ready, !m_full);
        check($sformatf("lane%0d bclk", g), bclk, (cyc / CD) % 2);
        if (und) ucnt++;
        if (prev_bclk && !bclk) slot = (slot + 1) % (2 * W);
        if (!prev_bclk && bclk && slot >= 0) begin
          word[2*W-1-slot] = sdata;
          check($sformatf("lane%0d lrck slot %0d", g, slot), lrck, ((slot + 1) % (2 * W)) >= W);
          if (slot == 2 * W - 1) begin
            check($sformatf("lane%0d frames pending", g), exp_q.size(), 1);
            if (exp_q.size() > 0) begin
              ef = exp_q.pop_front();
              check($sformatf("lane%0d left", g), word[2*W-1:W], ef.l);
              check($sformatf("lane%0d right", g), word[W-1:0], ef.r);
              check($sformatf("lane%0d underrun count", g), ucnt, ef.und ? 1 : 0);
            end
            ucnt = 0;
          end
        end
        prev_bclk = bclk;
      end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
      bit r;
      int budget;
      in_l     = a;
      in_r     = b;
      in_valid = 1'b1;
      budget   = 3 * F;
      do begin
        r = in_ready;
        @(negedge clk);
        budget--;
      end while (!r && budget > 0);
      if (!r) check($sformatf("lane%0d accept timeout", g), r, 1);
    endtask

    initial begin
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2 * F) @(negedge clk);

      send(16'hA5C3, 16'h8001);
      in_valid = 1'b0;
      repeat (3 * F) @(negedge clk);

      for (int i = 0; i < 8; i++) begin
        repeat ($urandom_range(0, F)) @(negedge clk);
        send(16'($urandom), 16'($urandom));
        in_valid = 1'b0;
      end

      for (int n = 1; n <= 6; n++) send(16'(n), ~16'(n));
      in_valid = 1'b0;
      repeat (2 * F) @(negedge clk);

      // Offer a pair so that it is accepted on the very clk of a frame start.
      while ((cyc + 1) % F != 2 * CD) @(negedge clk);
      send(16'h1234, 16'hFEDC);
      in_valid = 1'b0;
      repeat (2 * F) @(negedge clk);

      // Fill the buffer just after a frame start, then reset mid-right-channel with BCLK high.
      while ((cyc + 1) % F != 4 * CD) @(negedge clk);
      send(16'h0F0F, 16'hF0F0);
      in_valid = 1'b0;
      while ((cyc % F) != 2 * CD * 21 + CD) @(negedge clk);
      check($sformatf("lane%0d pre-reset bclk/lrck/ready", g), {bclk, lrck, in_ready}, 3'b110);
      rst_n = 1'b0;
      #1;
      check($sformatf("lane%0d async reset outputs", g), {in_ready, bclk, lrck, sdata, und}, 5'b10000);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      send(16'h7FFF, 16'h8000);
      in_valid = 1'b0;
      repeat (3 * F) @(negedge clk);

      check($sformatf("lane%0d frames left over", g), exp_q.size() <= 1, 1);
      done[g] = 1'b1;
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(done[0] && done[1]) && t < 60000) begin
      @(negedge clk);
      t++;
    end
    check("run completes", {done[0], done[1]}, 2'b11);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
